// File: rtl/lsu_mem_if.sv
// Load/store initiator: one RV32 load/store per request, translated to a word/lane memory access.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module lsu_mem_if #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [3:0]    mem_sel,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with rsp_valid && rsp_ready.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e        state_q,     state_d;
    logic          req_ready_q, req_ready_d;
    logic          mem_ce_q,    mem_ce_d;
    logic          mem_we_q,    mem_we_d;
    logic [DW-1:0] mem_addr_q,  mem_addr_d;
    logic [3:0]    mem_sel_q,   mem_sel_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]    f3_q,        f3_d;
    logic [1:0]    off_q,       off_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q,  rsp_data_d;
    logic          rsp_err_q,   rsp_err_d;

    logic [1:0]    req_size;
    logic [1:0]    req_off;
    logic          req_legal;
    logic          req_trap;
    logic [3:0]    req_sel;
    logic [DW-1:0] req_wrep;

    function automatic logic [DW-1:0] load_extract(input logic [2:0]    f3,
                                                   input logic [1:0]    off,
                                                   input logic [DW-1:0] rdata);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{(DW-8){b[7]}}, b};
            3'b100:  r = {{(DW-8){1'b0}}, b};
            3'b001:  r = {{(DW-16){h[15]}}, h};
            3'b101:  r = {{(DW-16){1'b0}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Request decode, evaluated only on the accept edge.
    always_comb begin
        req_size = req_funct3[1:0];

        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                        (req_funct3 != 3'b111);
        end

`ifdef LSU_MISALIGN_TRAP_EN
        req_trap = ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
        req_trap = 1'b0;
`endif

        // Misaligned offsets fall back to the natural alignment of the size.
        case (req_size)
            2'd0:    req_off = req_addr[1:0];
            2'd1:    req_off = {req_addr[1], 1'b0};
            default: req_off = 2'b00;
        endcase

        case (req_size)
            2'd0:    req_sel = 4'b0001 << req_off;
            2'd1:    req_sel = req_off[1] ? 4'b1100 : 4'b0011;
            default: req_sel = 4'b1111;
        endcase

        case (req_size)
            2'd0:    req_wrep = {4{req_wdata[7:0]}};
            2'd1:    req_wrep = {2{req_wdata[15:0]}};
            default: req_wrep = req_wdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_sel_d   = mem_sel_q;
        mem_wdata_d = mem_wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    f3_d  = req_funct3;
                    off_d = req_off;
                    if (!req_legal || req_trap) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_ce_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[DW-1:2], 2'b00};
                        mem_sel_d   = req_sel;
                        mem_wdata_d = req_we ? req_wrep : '0;
                    end
                end
            end
            ST_ACCESS: begin
                // The write commits in memory on this edge; loads sample rdata here.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = mem_we_q ? '0 : load_extract(f3_q, off_q, mem_rdata);
                mem_ce_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_sel_d   = '0;
                mem_wdata_d = '0;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                mem_ce_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_sel_d   = '0;
                mem_wdata_d = '0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            mem_wdata_q <= mem_wdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_sel   = mem_sel_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store initiator that sits between the execute/memory stage and the data port of the unified instruction/data memory. It accepts one RISC-V load or store per handshake, converts it into the memory's word-address, byte-lane-select, and write-enable protocol, and samples the combinational read data. It then returns an extended load result or a store completion through a ready/valid response channel. Stores commit on the clock edge ending the ACCESS cycle.

## Interface
- `DW`, 32: data and address width; fixed at 32 for RV32.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` input 32: effective byte address.
- `req_wdata` input 32: store data; lowest bytes are significant.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output 32: extended load data; 0 for stores and errors.
- `rsp_err` output 1: illegal funct3, or misaligned access when the trap is enabled.
- `mem_ce` output 1: memory chip enable.
- `mem_we` output 1: memory write enable.
- `mem_addr` output 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_sel` output 4: byte-lane enables; bit k = byte at offset k = data bits [8k+7:8k].
- `mem_wdata` output 32: lane-replicated store data.
- `mem_rdata` input 32: combinational read word, little-endian lanes.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture we, funct3, addr, and wdata.
  - Legal and aligned request: go to ACCESS.
  - Illegal or trapped request: go to RESP with `rsp_err`=1, and do not touch memory.
- **ACCESS (exactly 1 cycle):**
  - Drive `mem_ce`=1, `mem_we`=captured we, `mem_addr`, and `mem_sel`.
  - For loads, capture `mem_rdata` at the cycle-ending edge.
  - Go to RESP.
- **RESP:**
  - `rsp_valid`=1; data and err are held stable.
  - Return to IDLE on `rsp_ready`.
- **Lane selection** (offset o = addr[1:0]):
  - Byte: `mem_sel` = 1<<o.
  - Half: `mem_sel` = 0011 (o=0) or 1100 (o=2).
  - Word: `mem_sel` = 1111.
- **Store data:**
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: wdata.
- **Load extract:**
  - Byte: `rdata[8o+7:8o]`, sign-extended for LB, zero-extended for LBU.
  - Half: `rdata[16(o/2)+15:16(o/2)]`, sign-extended for LH, zero-extended for LHU.
  - Word: rdata.
- **Illegal funct3:** loads 011/110/111 and stores 011–111 always produce the error response, with no memory access.
- **Idle memory outputs:** when not in ACCESS, `mem_ce`, `mem_we`, `mem_sel`, `mem_addr`, and `mem_wdata` are all 0.

## Timing
- **Reset values:** `req_ready`=0 while `rst_n`=0, then 1 in IDLE. All other outputs are 0.
- **Reset mid-operation:** asserting `rst_n` low forces IDLE immediately and drives all memory outputs to 0. A store caught in ACCESS is not committed unless the clock edge precedes reset.
- **Normal latency:** accept edge T0, ACCESS during cycle T0+1, `rsp_valid` from T0+2. Minimum throughput is one operation per 3 cycles.
- **Error latency:** the error path skips ACCESS; `rsp_valid` is asserted the cycle after acceptance.
- **Back-to-back requests:** no new request is accepted in the same cycle a response is consumed. `req_ready` rises the cycle after the RESP→IDLE transition.
- **Back-pressure:** `rsp_valid` stays high and `rsp_data` is held constant while `rsp_ready`=0.
- **Request inputs:** sampled only on the accept edge; changes after that edge are ignored.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, returns `rsp_err`=1 and `rsp_data`=0.
  - No memory access is issued.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - Misaligned offsets are truncated to natural alignment: half uses o&2, word uses o=0.
  - The access proceeds normally with `rsp_err`=0.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 -> ACCESS shows `mem_sel`=1111, `mem_we`=1; load returns 0xDEADBEEF with `rsp_err`=0.
- SB 0x000000A5 @0x103 -> `mem_sel`=1000, `mem_wdata`=0xA5A5A5A5. Then LB @0x103 returns 0xFFFFFFA5, and LBU @0x103 returns 0x000000A5.
- SH 0x00008001 @0x106 -> `mem_sel`=1100. Then LH @0x106 returns 0xFFFF8001, and LHU @0x106 returns 0x00008001.
- LW @0x102:
  - With the macro: error response one cycle after accept, `mem_ce` never asserted.
  - Without the macro: reads word @0x100 with `rsp_err`=0.
- Hold `rsp_ready`=0 for 3 cycles after a load -> `rsp_valid` and `rsp_data` stable, `req_ready`=0. Release -> IDLE the next cycle.
- Pull `rst_n` low during the ACCESS cycle of SW 0x12345678 @0x200 -> outputs zero immediately; a later LW @0x200 returns the old value.
